// File: rtl/sram_device_model_pkg.sv
// ============================================================================
// Module : sram_device_model_pkg
// Brief  : Shared widths, FSM encoding and helpers for the SRAM device model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sram_device_model_pkg;

   localparam int SRAM_ADDR_LEN = 18;
   localparam int SRAM_DATA_LEN = 16;

   typedef enum logic [1:0] {
      SRAM_M_IDLE  = 2'd0,
      SRAM_M_WAIT  = 2'd1,
      SRAM_M_DRIVE = 2'd2
   } sram_state_e;

   // Latency counter preload; the counter expires one cycle after reaching zero.
   function automatic logic [3:0] lat_reload(input int lat);
      return 4'(lat - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_byte_bank.sv
// ============================================================================
// Module : sram_byte_bank
// Brief  : One byte lane of the SRAM array, synchronous write, registered
//          write-first read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_byte_bank #(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_waddr,
   input  logic [7:0]            i_wdata,
   input  logic [DEPTH_LOG2-1:0] i_raddr,
   output logic [7:0]            o_rdata
);

   logic [7:0] r_mem [0:(1<<DEPTH_LOG2)-1];
   logic [7:0] r_rdata;

   // Array contents survive reset, so this block has no reset branch.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_we && (i_waddr == i_raddr)) begin
         r_rdata <= i_wdata;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sram_device_model.sv
// ============================================================================
// Module : sram_device_model
// Brief  : Clock-synchronous responder emulating a 16-bit async SRAM chip with
//          programmable read latency, access counters and protocol-error flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_device_model
   import sram_device_model_pkg::*;
#(
   parameter int ADDR_W     = SRAM_ADDR_LEN,
   parameter int DATA_W     = SRAM_DATA_LEN,
   parameter int DEPTH_LOG2 = 12,
   parameter int READ_LAT   = 2
) (
   input  logic              clk,
   input  logic              rst,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   input  logic [ADDR_W-1:0] SRAM_ADDR,
   input  logic              SRAM_UB_N,
   input  logic              SRAM_LB_N,
   input  logic              SRAM_WE_N,
   input  logic              SRAM_CE_N,
   input  logic              SRAM_OE_N,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count,
   output logic              proto_err
);

   localparam logic [3:0] c_lat_reload = lat_reload(READ_LAT);

   sram_state_e       r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_addr_q, w_addr_nxt;
   logic [3:0]        r_lat_cnt, w_lat_nxt;
   logic              w_rd_done;
   logic              r_prev_wr;
   logic [31:0]       r_rd_count, r_wr_count;
   logic              r_proto_err;
   logic              w_wr, w_rd_req, w_addr_chg, w_drive;
   logic [1:0]        w_lane_n;
   logic [DATA_W-1:0] w_rd_data;

   assign w_wr       = ~SRAM_CE_N & ~SRAM_WE_N;
   assign w_rd_req   = ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N;
   assign w_addr_chg = (SRAM_ADDR != r_addr_q);
   assign w_drive    = (r_state == SRAM_M_DRIVE) & w_rd_req;
   assign w_lane_n   = {SRAM_UB_N, SRAM_LB_N};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= SRAM_M_IDLE;
         r_addr_q  <= '0;
         r_lat_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr_q  <= w_addr_nxt;
         r_lat_cnt <= w_lat_nxt;
      end
   end

   // A write edge always drops the read request (WE_N low), so writes win.
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr_q;
      w_lat_nxt   = r_lat_cnt;
      w_rd_done   = 1'b0;
      case (r_state)
         SRAM_M_IDLE: begin
            if (w_rd_req) begin
               w_state_nxt = SRAM_M_WAIT;
               w_addr_nxt  = SRAM_ADDR;
               w_lat_nxt   = c_lat_reload;
            end
         end
         SRAM_M_WAIT: begin
            if (!w_rd_req) begin
               w_state_nxt = SRAM_M_IDLE;
            end else if (w_addr_chg) begin
               w_addr_nxt  = SRAM_ADDR;
               w_lat_nxt   = c_lat_reload;
            end else if (r_lat_cnt == 4'd0) begin
               w_state_nxt = SRAM_M_DRIVE;
               w_rd_done   = 1'b1;
            end else begin
               w_lat_nxt   = r_lat_cnt - 4'd1;
            end
         end
         SRAM_M_DRIVE: begin
            if (!w_rd_req) begin
               w_state_nxt = SRAM_M_IDLE;
            end else if (w_addr_chg) begin
               w_state_nxt = SRAM_M_WAIT;
               w_addr_nxt  = SRAM_ADDR;
               w_lat_nxt   = c_lat_reload;
            end
         end
         default: begin
            w_state_nxt = SRAM_M_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_count  <= '0;
         r_wr_count  <= '0;
         r_prev_wr   <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_prev_wr <= w_wr;
         if (w_rd_done) begin
            r_rd_count <= r_rd_count + 32'd1;
         end
         if (w_wr && !r_prev_wr) begin
            r_wr_count <= r_wr_count + 32'd1;
         end
         if (w_wr && !SRAM_OE_N) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign rd_count  = r_rd_count;
   assign wr_count  = r_wr_count;
   assign proto_err = r_proto_err;

   for (genvar g = 0; g < 2; g++) begin : g_lane
      sram_byte_bank #(
         .DEPTH_LOG2 (DEPTH_LOG2)
      ) u_bank (
         .clk     (clk),
         .i_we    (w_wr & ~w_lane_n[g]),
         .i_waddr (SRAM_ADDR[DEPTH_LOG2-1:0]),
         .i_wdata (SRAM_DQ[8*g +: 8]),
         .i_raddr (r_addr_q[DEPTH_LOG2-1:0]),
         .o_rdata (w_rd_data[8*g +: 8])
      );

      assign SRAM_DQ[8*g +: 8] = (w_drive & ~w_lane_n[g]) ? w_rd_data[8*g +: 8] : 8'bzzzz_zzzz;
   end

endmodule

`default_nettype wire

// File: tb/tb_sram_device_model.sv
// ============================================================================
// Module : tb_sram_device_model
// Brief  : Directed self-checking bench for sram_device_model; bus pulled high.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_device_model;

   localparam logic [15:0] c_rel = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst;
   tri1  [15:0] sram_dq;
   logic [17:0] addr;
   logic        ub_n, lb_n, we_n, ce_n, oe_n;
   logic [31:0] rd_count, wr_count;
   logic        proto_err;
   logic [15:0] tb_drv;
   logic        tb_oe;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] burst [0:3];

   assign sram_dq = tb_oe ? tb_drv : 16'hzzzz;

   always #5 clk = ~clk;

   sram_device_model #(
      .ADDR_W     (18),
      .DATA_W     (16),
      .DEPTH_LOG2 (12),
      .READ_LAT   (2)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .SRAM_DQ   (sram_dq),
      .SRAM_ADDR (addr),
      .SRAM_UB_N (ub_n),
      .SRAM_LB_N (lb_n),
      .SRAM_WE_N (we_n),
      .SRAM_CE_N (ce_n),
      .SRAM_OE_N (oe_n),
      .rd_count  (rd_count),
      .wr_count  (wr_count),
      .proto_err (proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      burst[0] = 16'h1111;
      burst[1] = 16'h2222;
      burst[2] = 16'h4444;
      burst[3] = 16'h8888;

      rst = 1'b1; addr = '0; ub_n = 1'b0; lb_n = 1'b0;
      we_n = 1'b1; ce_n = 1'b1; oe_n = 1'b1; tb_drv = '0; tb_oe = 1'b0;
      tick(3);
      chk("rst_rd", rd_count, 32'd0);
      chk("rst_wr", wr_count, 32'd0);
      chk("rst_perr", {31'd0, proto_err}, 32'd0);
      chk("rst_dq", {16'd0, sram_dq}, {16'd0, c_rel});
      rst = 1'b0;

      // Full-word write held two edges, then read with latency 2
      addr = 18'h00010; tb_drv = 16'hBEEF; tb_oe = 1'b1; ce_n = 1'b0; we_n = 1'b0;
      tick(2);
      we_n = 1'b1; tb_oe = 1'b0; oe_n = 1'b0;
      tick();
      chk("rd1_lat0", {16'd0, sram_dq}, {16'd0, c_rel});
      tick();
      chk("rd1_lat1", {16'd0, sram_dq}, {16'd0, c_rel});
      tick();
      chk("rd1_data", {16'd0, sram_dq}, 32'h0000_BEEF);
      chk("rd1_wr", wr_count, 32'd1);
      chk("rd1_rd", rd_count, 32'd1);
      ce_n = 1'b1; oe_n = 1'b1;
      tick();
      chk("rd1_rel", {16'd0, sram_dq}, {16'd0, c_rel});

      // High-lane-only write, then full and masked reads
      tb_drv = 16'h12AB; tb_oe = 1'b1; ce_n = 1'b0; we_n = 1'b0; lb_n = 1'b1;
      tick();
      we_n = 1'b1; tb_oe = 1'b0; lb_n = 1'b0; oe_n = 1'b0;
      tick(3);
      chk("mask_rd", {16'd0, sram_dq}, 32'h0000_12EF);
      ub_n = 1'b1;
      #1;
      chk("ub_off", {16'd0, sram_dq}, 32'h0000_FFEF);
      ce_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0;
      tick();
      chk("mask_wr", wr_count, 32'd2);
      chk("mask_rdc", rd_count, 32'd2);

      // Contiguous write burst counts once
      ce_n = 1'b0; we_n = 1'b0; tb_oe = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr = 18'h00100 + 18'(i); tb_drv = burst[i];
         tick();
      end
      we_n = 1'b1; tb_oe = 1'b0; ce_n = 1'b1;
      tick();
      chk("burst_wr", wr_count, 32'd3);

      // Back-to-back reads, OE held, address stepping every 3 cycles
      ce_n = 1'b0; oe_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addr = 18'h00100 + 18'(i);
         tick();
         chk($sformatf("b2b%0d_gap0", i), {16'd0, sram_dq}, {16'd0, c_rel});
         tick();
         chk($sformatf("b2b%0d_gap1", i), {16'd0, sram_dq}, {16'd0, c_rel});
         tick();
         chk($sformatf("b2b%0d_data", i), {16'd0, sram_dq}, {16'd0, burst[i]});
      end
      chk("b2b_rd", rd_count, 32'd6);
      ce_n = 1'b1; oe_n = 1'b1;
      tick();

      // WE_N and OE_N together: write lands, bus not driven, error sticks
      addr = 18'h00020; tb_drv = 16'h5555; tb_oe = 1'b1; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
      tick();
      chk("perr_set", {31'd0, proto_err}, 32'd1);
      tb_oe = 1'b0;
      #1;
      chk("perr_dq", {16'd0, sram_dq}, {16'd0, c_rel});
      we_n = 1'b1; oe_n = 1'b1; ce_n = 1'b1;
      tick();
      chk("perr_wr", wr_count, 32'd4);
      ce_n = 1'b0; oe_n = 1'b0;
      tick(3);
      chk("perr_mem", {16'd0, sram_dq}, 32'h0000_5555);
      chk("perr_rdc", rd_count, 32'd7);
      ce_n = 1'b1; oe_n = 1'b1;
      tick(2);
      chk("perr_hold", {31'd0, proto_err}, 32'd1);

      // Reset during WAIT of an in-flight read
      addr = 18'h00010; ce_n = 1'b0; oe_n = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("rstw_dq0", {16'd0, sram_dq}, {16'd0, c_rel});
      tick();
      chk("rstw_dq1", {16'd0, sram_dq}, {16'd0, c_rel});
      rst = 1'b0; ce_n = 1'b1; oe_n = 1'b1;
      tick();
      chk("rstw_rd", rd_count, 32'd0);
      chk("rstw_wr", wr_count, 32'd0);
      chk("rstw_perr", {31'd0, proto_err}, 32'd0);
      ce_n = 1'b0; oe_n = 1'b0;
      tick(3);
      chk("rstw_mem", {16'd0, sram_dq}, 32'h0000_12EF);
      chk("rstw_rdc", rd_count, 32'd1);
      ce_n = 1'b1; oe_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
